// File: rtl/shift_reg_ctrl.sv
// rtl/shift_reg_ctrl.sv - frame sequencer driving an external universal shift register
//
// Accepts parallel words over a valid/ready handshake, parallel-loads each
// word into the attached shift_reg and clocks it out LSB-first, DIV clock
// cycles per bit. Back-to-back frames are sent with no gap cycle.
//
// Optional feature: define SHIFT_REG_CTRL_PARITY_EN to append one even-parity
// bit (DIV cycles long) after the data bits of every frame.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   in_valid        producer has a word
//   in_data [N]     word to send, sampled on accept
//   in_ready        block can accept (no path from in_valid)
//   sr_ctrl [2]     shift_reg.ctrl (00 hold, 01 shift right, 10 load)
//   sr_d [N]        shift_reg.d, pass-through of in_data
//   sr_s_in         shift_reg.s_in, constant 0 fill bit
//   sr_s_out        shift_reg.s_out, current LSB
//   ser_out         serial data bit
//   ser_valid       ser_out carries a frame bit
//   busy            frame in progress
//   done            high during the final cycle of each frame
module shift_reg_ctrl #(
  parameter int N   = 8,
  parameter int DIV = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [N-1:0] in_data,
  output logic         in_ready,
  output logic [1:0]   sr_ctrl,
  output logic [N-1:0] sr_d,
  output logic         sr_s_in,
  input  logic         sr_s_out,
  output logic         ser_out,
  output logic         ser_valid,
  output logic         busy,
  output logic         done
);

  localparam int BW = $clog2(N + 2);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } state_t;

  state_t          state;
  logic [BW-1:0]   bit_cnt;
  logic [DW-1:0]   div_cnt;
  logic            bit_end;
  logic            last_data_bit;
  logic            frame_end;
  logic            accept;

  assign bit_end       = (div_cnt == DIV_LAST);
  assign last_data_bit = (state == SHIFT) && bit_end && (bit_cnt == BIT_LAST);

`ifdef SHIFT_REG_CTRL_PARITY_EN
  logic parity;
  assign frame_end = (state == PAR) && bit_end;
`else
  assign frame_end = last_data_bit;
`endif

  // rst gates in_ready so nothing is accepted while reset is held.
  assign in_ready = !rst && ((state == IDLE) || frame_end);
  assign accept   = in_valid && in_ready;

  assign sr_d      = in_data;
  assign sr_s_in   = 1'b0;
  assign ser_valid = (state != IDLE);
  assign busy      = (state != IDLE);
  assign done      = frame_end;

  // Load on accept; shift only at bit ends that still have a data bit to
  // follow, so the register is never shifted past the last data bit.
  always_comb begin
    sr_ctrl = 2'b00;
    if (accept) begin
      sr_ctrl = 2'b10;
    end else if ((state == SHIFT) && bit_end && (bit_cnt < BIT_LAST)) begin
      sr_ctrl = 2'b01;
    end
  end

  always_comb begin
    ser_out = 1'b0;
    if (state == SHIFT) begin
      ser_out = sr_s_out;
    end
`ifdef SHIFT_REG_CTRL_PARITY_EN
    else if (state == PAR) begin
      ser_out = parity;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      div_cnt <= '0;
`ifdef SHIFT_REG_CTRL_PARITY_EN
      parity  <= 1'b0;
`endif
    end else if (accept) begin
      // Covers both the IDLE accept and the zero-gap accept at frame end.
      state   <= SHIFT;
      bit_cnt <= '0;
      div_cnt <= '0;
`ifdef SHIFT_REG_CTRL_PARITY_EN
      parity  <= ^in_data;
`endif
    end else begin
      case (state)
        IDLE: begin
          div_cnt <= '0;
        end
        SHIFT: begin
          if (bit_end) begin
            div_cnt <= '0;
            bit_cnt <= bit_cnt + BW'(1);
            if (last_data_bit) begin
`ifdef SHIFT_REG_CTRL_PARITY_EN
              state <= PAR;
`else
              state <= IDLE;
`endif
            end
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
`ifdef SHIFT_REG_CTRL_PARITY_EN
        PAR: begin
          if (bit_end) begin
            div_cnt <= '0;
            state   <= IDLE;
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
`endif
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  a_no_ctrl_11: assert property (@(posedge clk) disable iff (rst) sr_ctrl != 2'b11);

endmodule

// File: tb/tb_shift_reg_ctrl.sv
// tb/tb_shift_reg_ctrl.sv - randomized bench for shift_reg_ctrl at DIV=1 and DIV=3
module tb_shift_reg_ctrl;

  localparam int N = 8;
`ifdef SHIFT_REG_CTRL_PARITY_EN
  localparam int NB = N + 1;
`else
  localparam int NB = N;
`endif
  localparam int DIVS [2] = '{1, 3};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [N-1:0] in_data = '0;

  logic         in_ready  [2];
  logic [1:0]   sr_ctrl   [2];
  logic [N-1:0] sr_d      [2];
  logic         sr_s_in   [2];
  logic         ser_out   [2];
  logic         ser_valid [2];
  logic         busy      [2];
  logic         done      [2];
  logic [N-1:0] sreg      [2];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  shift_reg_ctrl #(.N(N), .DIV(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready[0]), .sr_ctrl(sr_ctrl[0]), .sr_d(sr_d[0]),
    .sr_s_in(sr_s_in[0]), .sr_s_out(sreg[0][0]), .ser_out(ser_out[0]),
    .ser_valid(ser_valid[0]), .busy(busy[0]), .done(done[0])
  );

  shift_reg_ctrl #(.N(N), .DIV(3)) u_dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready[1]), .sr_ctrl(sr_ctrl[1]), .sr_d(sr_d[1]),
    .sr_s_in(sr_s_in[1]), .sr_s_out(sreg[1][0]), .ser_out(ser_out[1]),
    .ser_valid(ser_valid[1]), .busy(busy[1]), .done(done[1])
  );

  // Attached universal shift registers (environment, not the reference).
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      case (sr_ctrl[i])
        2'b10:   sreg[i] <= sr_d[i];
        2'b01:   sreg[i] <= {sr_s_in[i], sreg[i][N-1:1]};
        default: sreg[i] <= sreg[i];
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: a frame is NB*DIV cycles after the accept; frame cycle c
  // carries bit c/DIV of the word (bit N being even parity).
  logic         act  [2] = '{1'b0, 1'b0};
  int           cyc  [2] = '{0, 0};
  logic [N-1:0] word [2];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int fl, b;
      logic rdy_e, done_e, out_e, acc;
      logic [1:0] ctrl_e;
      string p;
      p = $sformatf("div%0d", DIVS[i]);
      fl = NB * DIVS[i];
      if (rst) begin
        act[i] = 1'b0;
        check({p, " rst in_ready"}, in_ready[i], 0);
        check({p, " rst sr_ctrl"}, sr_ctrl[i], 0);
        check({p, " rst ser_valid"}, ser_valid[i], 0);
        check({p, " rst ser_out"}, ser_out[i], 0);
        check({p, " rst busy"}, busy[i], 0);
        check({p, " rst done"}, done[i], 0);
      end else begin
        rdy_e  = !act[i] || (cyc[i] == fl - 1);
        done_e = act[i] && (cyc[i] == fl - 1);
        b      = cyc[i] / DIVS[i];
        out_e  = (b < N) ? word[i][b] : ^word[i];
        acc    = in_valid && rdy_e;
        if (acc) ctrl_e = 2'b10;
        else if (act[i] && (cyc[i] % DIVS[i] == DIVS[i] - 1) && (b < N - 1)) ctrl_e = 2'b01;
        else ctrl_e = 2'b00;
        check({p, " in_ready"}, in_ready[i], rdy_e);
        check({p, " done"}, done[i], done_e);
        check({p, " ser_valid"}, ser_valid[i], act[i]);
        check({p, " busy"}, busy[i], act[i]);
        check({p, " sr_ctrl"}, sr_ctrl[i], ctrl_e);
        check({p, " sr_d"}, sr_d[i], in_data);
        check({p, " sr_s_in"}, sr_s_in[i], 0);
        if (act[i]) check($sformatf("%s ser_out bit%0d", p, b), ser_out[i], out_e);
        if (acc) begin
          act[i] = 1'b1;
          cyc[i] = 0;
          word[i] = in_data;
        end else if (act[i]) begin
          if (cyc[i] == fl - 1) act[i] = 1'b0;
          else cyc[i]++;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    step(3);
    rst = 1'b0;
    step(2);

    // 0xA5 into both idle instances, then 0x3C held for back-to-back frames.
    in_valid = 1'b1;
    in_data  = 8'hA5;
    step(1);
    in_data  = 8'h3C;
    step(60);

    // 0x81 frames, then data toggling every cycle with in_valid held.
    in_data = 8'h81;
    step(60);
    for (int k = 0; k < 80; k++) begin
      in_data = N'($urandom);
      step(1);
    end

    // Asynchronous reset mid-frame after a few bits.
    in_valid = 1'b0;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'hFF;
    step(1);
    in_valid = 1'b0;
    step(3);
    #2;
    check("pre-rst busy", {busy[1], busy[0]}, 2'b11);
    rst = 1'b1;
    #1;
    check("async ser_valid", {ser_valid[1], ser_valid[0]}, 2'b00);
    check("async busy", {busy[1], busy[0]}, 2'b00);
    check("async in_ready", {in_ready[1], in_ready[0]}, 2'b00);
    step(2);
    rst = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'hFF;
    step(1);
    in_valid = 1'b0;
    step(40);

    // Random traffic with occasional resets.
    for (int k = 0; k < 3000; k++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = N'($urandom);
      if ($urandom_range(0, 399) == 0) begin
        rst = 1'b1;
        step(1);
        rst = 1'b0;
      end
      step(1);
    end

    in_valid = 1'b0;
    step(40);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
